// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock time-of-day core.
//   state_e  : set-mode FSM states (RUN, SET_HR, SET_MIN)
//   BCD_W    : width of one BCD digit
//   *_LIMIT  : highest legal value of a units digit, a tens-of-seconds/minutes
//              digit, and of the hour in 24 h and 12 h display modes
//   to_bcd() : splits a binary value 0..99 into {tens, units} BCD nibbles,
//              used to turn the reset/limit parameters into digit values
// ----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam int BCD_W       = 4;
    localparam int UNITS_LIMIT = 9;
    localparam int TENS_LIMIT  = 5;
    localparam int HR24_LIMIT  = 23;
    localparam int HR12_LIMIT  = 12;

    function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
        tens  = BCD_W'(value / 10);
        units = BCD_W'(value % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/clock_bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter (tens/units) that counts up to MAX and then wraps to
// WRAP. Used for seconds and minutes (MAX=59, WRAP=0) and for hours
// (MAX=23/WRAP=0 or MAX=12/WRAP=1).
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset (loads RESET_VAL)
//   inc        : advance by one this cycle
//   clr        : load the WRAP value (takes priority over inc)
//   carry_out  : combinational, high when inc arrives while at MAX, i.e. the
//                cycle in which this pair wraps
//   tens/units : registered BCD digits
// ----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX       = 59,
    parameter int WRAP      = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic             carry_out,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    localparam logic [2*BCD_W-1:0] MAX_BCD   = to_bcd(MAX);
    localparam logic [2*BCD_W-1:0] WRAP_BCD  = to_bcd(WRAP);
    localparam logic [2*BCD_W-1:0] RESET_BCD = to_bcd(RESET_VAL);

    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] tens_d;
    logic [BCD_W-1:0] units_q;
    logic [BCD_W-1:0] units_d;
    logic             at_max;

    assign at_max = ({tens_q, units_q} == MAX_BCD);

    // The carry reflects the increment even when clr wins, so a tick that
    // lands together with a clear still ripples into the next pair.
    assign carry_out = inc & at_max;

    // Next value: wrap at MAX, otherwise a plain BCD +1 with units->tens carry.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            {tens_d, units_d} = WRAP_BCD;
        end else if (inc) begin
            if (at_max) begin
                {tens_d, units_d} = WRAP_BCD;
            end else if (units_q == BCD_W'(UNITS_LIMIT)) begin
                tens_d  = tens_q + 4'd1;
                units_d = '0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= RESET_BCD[2*BCD_W-1:BCD_W];
            units_q <= RESET_BCD[BCD_W-1:0];
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/clock_timekeeper.sv
// ----------------------------------------------------------------------------
// clock_timekeeper
// Time-of-day core of the digital clock. Counts BCD HH:MM:SS from the
// divider's 1 Hz square wave, runs the RUN -> SET_HR -> SET_MIN set-mode FSM
// from debounced buttons, and produces blank flags that blink the field being
// set at 2 Hz.
// Parameters:
//   HOUR_MODULO : 24 (hours 00..23) or 12 (hours 01..12, 12 -> 01)
//   RESET_HR    : hour loaded at reset
//   RESET_MIN   : minute loaded at reset
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   clk_1HZ             : 1 Hz square wave, rising edge = one second
//   clk_2HZ             : 2 Hz square wave, low phase = blank phase
//   btn_mode, btn_inc   : one-cycle debounced button pulses
//   hr_t .. sec_u       : BCD time digits
//   blank_hr, blank_min : blank requests for the digits being set
//   day_pulse           : one-cycle pulse when the time rolls over the day
// ----------------------------------------------------------------------------
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int HOUR_MODULO = 24,
    parameter int RESET_HR    = 0,
    parameter int RESET_MIN   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1HZ,
    input  logic             clk_2HZ,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic [BCD_W-1:0] hr_t,
    output logic [BCD_W-1:0] hr_u,
    output logic [BCD_W-1:0] min_t,
    output logic [BCD_W-1:0] min_u,
    output logic [BCD_W-1:0] sec_t,
    output logic [BCD_W-1:0] sec_u,
    output logic             blank_hr,
    output logic             blank_min,
    output logic             day_pulse
);

    localparam int MS_MAX  = TENS_LIMIT * 10 + UNITS_LIMIT;
    localparam int HR_MAX  = (HOUR_MODULO == 12) ? HR12_LIMIT : HR24_LIMIT;
    localparam int HR_WRAP = (HOUR_MODULO == 12) ? 1 : 0;

    state_e state_q;
    state_e state_d;
    logic   prev_1hz_q;
    logic   prev_1hz_d;
    logic   blank_hr_q;
    logic   blank_hr_d;
    logic   blank_min_q;
    logic   blank_min_d;
    logic   day_pulse_q;
    logic   day_pulse_d;

    logic   sec_tick;
    logic   is_run;
    logic   is_set_hr;
    logic   is_set_min;
    logic   inc_accept;
    logic   sec_inc;
    logic   sec_clr;
    logic   min_inc;
    logic   hr_inc;
    logic   sec_carry;
    logic   min_carry;
    logic   hr_carry;

    // One second per rising edge of the divider's 1 Hz level. The history
    // flop resets to 1 so a wave that is already high at release is not
    // mistaken for a fresh edge.
    assign sec_tick = clk_1HZ & ~prev_1hz_q;

    assign is_run     = (state_q == RUN);
    assign is_set_hr  = (state_q == SET_HR);
    assign is_set_min = (state_q == SET_MIN);

    // A mode press in the same cycle swallows any increment press.
    assign inc_accept = btn_inc & ~btn_mode;

    // Seconds only count in RUN. Leaving RUN clears them; the tick of that
    // same cycle still produces its minute/hour carry through sec_carry.
    assign sec_inc = is_run & sec_tick;
    assign sec_clr = is_run & btn_mode;

    // Minutes advance from the seconds carry in RUN or from the button in
    // SET_MIN; the button path never carries into the hours.
    assign min_inc = (is_run & sec_carry) | (is_set_min & inc_accept);
    assign hr_inc  = (is_run & min_carry) | (is_set_hr & inc_accept);

    // Only a running rollover marks a new day, never a set-mode wrap.
    assign day_pulse_d = is_run & hr_carry;

    // Set-mode FSM next state plus the registered blink requests, which
    // follow the current state and the 2 Hz phase.
    always_comb begin
        state_d     = state_q;
        prev_1hz_d  = clk_1HZ;
        blank_hr_d  = is_set_hr & ~clk_2HZ;
        blank_min_d = is_set_min & ~clk_2HZ;
        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                if (btn_mode) begin
                    state_d = SET_MIN;
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            prev_1hz_q  <= 1'b1;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_1hz_q  <= prev_1hz_d;
            blank_hr_q  <= blank_hr_d;
            blank_min_q <= blank_min_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    bcd_mod_counter #(
        .MAX       (MS_MAX),
        .WRAP      (0),
        .RESET_VAL (0)
    ) u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (sec_inc),
        .clr       (sec_clr),
        .carry_out (sec_carry),
        .tens      (sec_t),
        .units     (sec_u)
    );

    bcd_mod_counter #(
        .MAX       (MS_MAX),
        .WRAP      (0),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (min_inc),
        .clr       (1'b0),
        .carry_out (min_carry),
        .tens      (min_t),
        .units     (min_u)
    );

    bcd_mod_counter #(
        .MAX       (HR_MAX),
        .WRAP      (HR_WRAP),
        .RESET_VAL (RESET_HR)
    ) u_hr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (hr_inc),
        .clr       (1'b0),
        .carry_out (hr_carry),
        .tens      (hr_t),
        .units     (hr_u)
    );

    assign blank_hr  = blank_hr_q;
    assign blank_min = blank_min_q;
    assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// ----------------------------------------------------------------------------
// tb_clock_timekeeper
// Directed bench for clock_timekeeper (24 h mode, reset time 00:00). A
// reference model keeps the time as seconds-of-day and the set mode as a
// number; its outputs are compared with the DUT on every falling clock edge,
// and literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_clock_timekeeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_1hz = 1'b0;
    logic       clk_2hz = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       blank_hr;
    logic       blank_min;
    logic       day_pulse;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model state: seconds since midnight, mode 0=RUN 1=SET_HR 2=SET_MIN.
    int m_time = 0;
    int m_mode = 0;
    bit m_prev = 1'b1;
    bit m_blank_hr = 1'b0;
    bit m_blank_min = 1'b0;
    bit m_day = 1'b0;

    clock_timekeeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_1HZ   (clk_1hz),
        .clk_2HZ   (clk_2hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hr_t      (hr_t),
        .hr_u      (hr_u),
        .min_t     (min_t),
        .min_u     (min_u),
        .sec_t     (sec_t),
        .sec_u     (sec_u),
        .blank_hr  (blank_hr),
        .blank_min (blank_min),
        .day_pulse (day_pulse)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Time of day after one clock of the model, from the clock's rules.
    function automatic int nextTime(input int t, input int mode, input bit tick,
                                    input bit b_mode, input bit b_inc);
        int h  = t / 3600;
        int mi = (t / 60) % 60;
        int nt = t;
        case (mode)
            0: begin
                if (tick) nt = (t + 1) % 86400;
                if (b_mode) nt = nt - (nt % 60);
            end
            1: if (!b_mode && b_inc) nt = ((h + 1) % 24) * 3600 + mi * 60;
            2: if (!b_mode && b_inc) nt = h * 3600 + ((mi + 1) % 60) * 60;
            default: nt = t;
        endcase
        return nt;
    endfunction

    // Reference model, advanced on the same clock and reset as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_time      <= 0;
            m_mode      <= 0;
            m_prev      <= 1'b1;
            m_blank_hr  <= 1'b0;
            m_blank_min <= 1'b0;
            m_day       <= 1'b0;
        end else begin
            m_time      <= nextTime(m_time, m_mode, clk_1hz && !m_prev, btn_mode, btn_inc);
            m_mode      <= btn_mode ? (m_mode + 1) % 3 : m_mode;
            m_prev      <= clk_1hz;
            m_blank_hr  <= (m_mode == 1) && !clk_2hz;
            m_blank_min <= (m_mode == 2) && !clk_2hz;
            m_day       <= (m_mode == 0) && clk_1hz && !m_prev && (m_time == 86399);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkTime(input string tag, input int h, input int mi, input int s);
        checkOutput({tag, " hr_t"},  hr_t,  h / 10);
        checkOutput({tag, " hr_u"},  hr_u,  h % 10);
        checkOutput({tag, " min_t"}, min_t, mi / 10);
        checkOutput({tag, " min_u"}, min_u, mi % 10);
        checkOutput({tag, " sec_t"}, sec_t, s / 10);
        checkOutput({tag, " sec_u"}, sec_u, s % 10);
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model hr_t",  hr_t,  (m_time / 3600) / 10);
            checkOutput("model hr_u",  hr_u,  (m_time / 3600) % 10);
            checkOutput("model min_t", min_t, ((m_time / 60) % 60) / 10);
            checkOutput("model min_u", min_u, ((m_time / 60) % 60) % 10);
            checkOutput("model sec_t", sec_t, (m_time % 60) / 10);
            checkOutput("model sec_u", sec_u, (m_time % 60) % 10);
            checkOutput("model blank_hr",  blank_hr,  m_blank_hr);
            checkOutput("model blank_min", blank_min, m_blank_min);
            checkOutput("model day_pulse", day_pulse, m_day);
        end
    end

    // Drive one clock cycle worth of inputs, changed on the falling edge.
    task automatic applyStimulus(input logic b_mode, input logic b_inc,
                                 input logic c1, input logic c2);
        @(negedge clk);
        btn_mode = b_mode;
        btn_inc  = b_inc;
        clk_1hz  = c1;
        clk_2hz  = c2;
    endtask

    task automatic secondTicks(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic incPresses(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic modePress();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkTime("reset", 0, 0, 0);
        checkOutput("reset blank_hr", blank_hr, 0);
        checkOutput("reset day_pulse", day_pulse, 0);
        check_en = 1'b1;
        rst_n = 1'b1;

        $display("[TB] sixty seconds from reset");
        secondTicks(60);
        checkTime("60 ticks", 0, 1, 0);

        $display("[TB] set hours and minutes");
        modePress();
        incPresses(23);
        checkTime("hour 23", 23, 1, 0);
        incPresses(1);
        checkTime("hour wrap", 0, 1, 0);
        incPresses(23);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkTime("mode+inc", 23, 1, 0);
        incPresses(58);
        checkTime("minute 59", 23, 59, 0);
        incPresses(1);
        checkTime("minute wrap", 23, 0, 0);
        incPresses(59);
        modePress();

        $display("[TB] day rollover");
        secondTicks(58);
        checkTime("23:59:58", 23, 59, 58);
        secondTicks(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkTime("rollover", 0, 0, 0);
        checkOutput("rollover day_pulse", day_pulse, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("day_pulse width", day_pulse, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] tick and mode together");
        secondTicks(59);
        checkTime("00:00:59", 0, 0, 59);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkTime("tick+mode", 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] hour blink");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, k[0]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("blink hr low phase", blank_hr, 1);
        checkOutput("blink min in SET_HR", blank_min, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("blink hr high phase", blank_hr, 0);
        secondTicks(1);
        checkTime("tick ignored", 0, 1, 0);

        $display("[TB] minute blink and reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("blink min low phase", blank_min, 1);
        checkOutput("blink hr in SET_MIN", blank_hr, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkTime("async reset", 0, 0, 0);
        checkOutput("async reset blank_min", blank_min, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkTime("no tick after release", 0, 0, 0);
        checkOutput("release blank_min", blank_min, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
